z80_add16_seq: RTL and testbench

Sequencer that performs a 16-bit Z80-style addition (ADD HL,rr class) by time-multiplexing one external 8-bit adder over two or three clock cycles. It sits between the register-file/control side and the shared 8-bit adder instance: it drives the adder operands each cycle, captures result and carry/half-carry, and handles inter-byte carry by an extra increment pass. The adder stays combinational and outside this block so other users can share it whenever this sequencer is idle.

---
 rtl/z80_add16_seq.sv | 119 +++++++++++
 tb/tb_z80_add16_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/z80_add16_seq.sv
// 16-bit Z80 ADD HL,rr sequencer: time-multiplexes one external 8-bit adder
// over LO/HI passes, with an extra INC pass to fold in the inter-byte carry.
module z80_add16_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        flag_c,
  output logic        flag_h,
  output logic        flag_z,
  output logic        flag_s,
  output logic        flag_n,
  output logic [7:0]  add_a,
  output logic [7:0]  add_b,
  input  logic [7:0]  add_result,
  input  logic        add_c,
  input  logic        add_h
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_INC,
    S_DONE
  } state_t;

  state_t      state, state_nx;
  logic [15:0] a_r, b_r;
  logic [7:0]  hi_r;
  logic        c_lo, c_hi, h_hi;
  logic        accept;

  assign busy   = (state == S_LO) || (state == S_HI) || (state == S_INC);
  assign done   = (state == S_DONE);
  assign flag_n = 1'b0;
  assign accept = start && !busy;

  always_comb begin
    state_nx = state;
    add_a    = '0;
    add_b    = '0;
    case (state)
      S_IDLE:  if (accept) state_nx = S_LO;
      S_LO: begin
        add_a    = a_r[7:0];
        add_b    = b_r[7:0];
        state_nx = S_HI;
      end
      S_HI: begin
        add_a    = a_r[15:8];
        add_b    = b_r[15:8];
        state_nx = c_lo ? S_INC : S_DONE;
      end
      S_INC: begin
        add_a    = hi_r;
        add_b    = 8'h01;
        state_nx = S_DONE;
      end
      S_DONE:  state_nx = accept ? S_LO : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // In both commit paths (HI without carry, INC) the final high byte is add_result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_r    <= '0;
      b_r    <= '0;
      hi_r   <= '0;
      c_lo   <= 1'b0;
      c_hi   <= 1'b0;
      h_hi   <= 1'b0;
      result <= '0;
      flag_c <= 1'b0;
      flag_h <= 1'b0;
      flag_z <= 1'b0;
      flag_s <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_r <= op_a;
        b_r <= op_b;
      end
      case (state)
        S_LO: begin
          result[7:0] <= add_result;
          c_lo        <= add_c;
        end
        S_HI: begin
          hi_r <= add_result;
          c_hi <= add_c;
          h_hi <= add_h;
          if (!c_lo) begin
            result[15:8] <= add_result;
            flag_c       <= add_c;
            flag_h       <= add_h;
            flag_z       <= ({add_result, result[7:0]} == 16'h0000);
            flag_s       <= add_result[7];
          end
        end
        S_INC: begin
          result[15:8] <= add_result;
          flag_c       <= c_hi | add_c;
          flag_h       <= h_hi | add_h;
          flag_z       <= ({add_result, result[7:0]} == 16'h0000);
          flag_s       <= add_result[7];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_add16_seq.sv
// Scoreboard bench for z80_add16_seq: directed vectors with hand-computed sums,
// flags and latencies; a monitor pops expectations on each done pulse.
module tb_z80_add16_seq;

  logic        clk, rst, start;
  logic [15:0] op_a, op_b;
  logic        busy, done;
  logic [15:0] result;
  logic        flag_c, flag_h, flag_z, flag_s, flag_n;
  logic [7:0]  add_a, add_b, add_result;
  logic        add_c, add_h;
  logic [8:0]  sum9;
  logic [4:0]  nib5;

  z80_add16_seq dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result),
    .flag_c(flag_c), .flag_h(flag_h), .flag_z(flag_z), .flag_s(flag_s), .flag_n(flag_n),
    .add_a(add_a), .add_b(add_b), .add_result(add_result), .add_c(add_c), .add_h(add_h)
  );

  // Shared 8-bit adder that lives outside the sequencer.
  assign sum9       = {1'b0, add_a} + {1'b0, add_b};
  assign nib5       = {1'b0, add_a[3:0]} + {1'b0, add_b[3:0]};
  assign add_result = sum9[7:0];
  assign add_c      = sum9[8];
  assign add_h      = nib5[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        c, h, z, s;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int unsigned busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [15:0] res, input logic c, input logic h,
                      input logic z, input logic s, input int unsigned lat);
    exp_t e;
    e.res = res; e.c = c; e.h = h; e.z = z; e.s = s; e.lat = lat;
    sb.push_back(e);
  endtask

  // Monitor: latency counts LO/HI/INC cycles plus the DONE cycle.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else if (done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {16'h0, result}, {16'h0, e.res});
        check("flag_c", {31'h0, flag_c}, {31'h0, e.c});
        check("flag_h", {31'h0, flag_h}, {31'h0, e.h});
        check("flag_z", {31'h0, flag_z}, {31'h0, e.z});
        check("flag_s", {31'h0, flag_s}, {31'h0, e.s});
        check("flag_n", {31'h0, flag_n}, 32'h0);
        check("latency", busy_cnt + 1, e.lat);
      end
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
    end
  end

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    int k;
    @(negedge clk);
    k = 0;
    while (busy && k < 20) begin @(negedge clk); k++; end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
    op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    int k;
    k = 0;
    while (done_cnt <= n0 && k < 20) begin @(posedge clk); k++; end
    if (done_cnt <= n0) check("done_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n0;
    int k;
    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    #12;
    check("rst_busy",   {31'h0, busy}, 32'h0);
    check("rst_done",   {31'h0, done}, 32'h0);
    check("rst_result", {16'h0, result}, 32'h0);
    check("rst_add_a",  {24'h0, add_a}, 32'h0);
    @(negedge clk); rst = 1'b0;

    // 1234 + 4321, adder operand sequence 34/21 then 12/43
    n0 = done_cnt;
    start_op(16'h1234, 16'h4321);
    push(16'h5555, 0, 0, 0, 0, 3);
    @(negedge clk);
    check("lo_add_a", {24'h0, add_a}, 32'h34);
    check("lo_add_b", {24'h0, add_b}, 32'h21);
    @(negedge clk);
    check("hi_add_a", {24'h0, add_a}, 32'h12);
    check("hi_add_b", {24'h0, add_b}, 32'h43);
    wait_done(n0);

    // 0FFF + 0001 takes the INC pass with 0F/01
    n0 = done_cnt;
    start_op(16'h0FFF, 16'h0001);
    push(16'h1000, 0, 1, 0, 0, 4);
    repeat (3) @(negedge clk);
    check("inc_add_a", {24'h0, add_a}, 32'h0F);
    check("inc_add_b", {24'h0, add_b}, 32'h01);
    wait_done(n0);

    n0 = done_cnt;
    start_op(16'hFFFF, 16'h0001);
    push(16'h0000, 1, 1, 1, 0, 4);
    wait_done(n0);

    n0 = done_cnt;
    start_op(16'h8000, 16'h8000);
    push(16'h0000, 1, 0, 1, 0, 3);
    wait_done(n0);

    n0 = done_cnt;
    start_op(16'h7FFF, 16'h0001);
    push(16'h8000, 0, 1, 0, 1, 4);
    wait_done(n0);

    // start pulsed during LO must be ignored
    n0 = done_cnt;
    start_op(16'h2345, 16'h1111);
    push(16'h3456, 0, 0, 0, 0, 3);
    op_a = 16'hFFFF; op_b = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n0);

    // start held through DONE: back-to-back with no IDLE cycle
    n0 = done_cnt;
    start_op(16'h1111, 16'h2222);
    push(16'h3333, 0, 0, 0, 0, 3);
    start = 1'b1; op_a = 16'hF000; op_b = 16'h1000;
    k = 0;
    @(negedge clk); #1;
    while (!done && k < 20) begin @(negedge clk); #1; k++; end
    if (!done) check("b2b_done_timeout", 32'd1, 32'd0);
    push(16'h0000, 1, 0, 1, 0, 3);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_no_idle", {31'h0, busy}, 32'h1);
    wait_done(n0 + 1);

    // reset during HI aborts with no done pulse
    n0 = done_cnt;
    start_op(16'h1234, 16'h0001);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check("abort_busy",   {31'h0, busy}, 32'h0);
    check("abort_done",   {31'h0, done}, 32'h0);
    check("abort_result", {16'h0, result}, 32'h0);
    check("abort_flags",  {28'h0, flag_c, flag_h, flag_z, flag_s}, 32'h0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_done", done_cnt, n0);

    n0 = done_cnt;
    start_op(16'h00FF, 16'h0001);
    push(16'h0100, 0, 0, 0, 0, 4);
    wait_done(n0);

    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
